// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised single-clock register file for the LEGv8 decode stage.
//
// Ports:
//   clk            - system clock, all state updates on the rising edge
//   reset          - synchronous, active-high; clears every register and every read port
//   read_register  - READ_PORTS packed read indices, port p at [p*AW +: AW]
//   read_data      - READ_PORTS packed registered read words, port p at [p*WIDTH +: WIDTH]
//   write_register - WRITE_PORTS packed write indices
//   write_data     - WRITE_PORTS packed write words
//   reg_write      - per-write-port enable
//
// Reads have one cycle of latency. With BYPASS=1 a read that hits a same-cycle write returns
// the new data (highest-numbered write port wins); with BYPASS=0 it returns the old contents.
// ZERO_REG always reads 0 and swallows writes; set it to DEPTH to get a plain register.
// Indices at or above DEPTH read 0 and drop writes.

module regfile_multiport #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 1,
  parameter int unsigned ZERO_REG    = 31,
  parameter int unsigned BYPASS      = 1,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [READ_PORTS*AW-1:0]      read_register,
  output logic [READ_PORTS*WIDTH-1:0]   read_data,
  input  logic [WRITE_PORTS*AW-1:0]     write_register,
  input  logic [WRITE_PORTS*WIDTH-1:0]  write_data,
  input  logic [WRITE_PORTS-1:0]        reg_write
);

  // An index is backed by real storage only if it is in range and not the zero register.
  function automatic logic addressable(input logic [AW-1:0] idx);
    return (32'(idx) < DEPTH) && (32'(idx) != ZERO_REG);
  endfunction

  // Architectural state and next state.
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];

  // Registered read ports.
  logic [READ_PORTS*WIDTH-1:0] rdata_q;
  logic [READ_PORTS*WIDTH-1:0] rdata_d;

  // Unpacked view of the write ports; wr_ok already folds in range and zero-register filtering,
  // so both the update path and the bypass path can trust it directly.
  logic [AW-1:0]    wr_idx [WRITE_PORTS];
  logic [WIDTH-1:0] wr_val [WRITE_PORTS];
  logic             wr_ok  [WRITE_PORTS];

  always_comb begin
    for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
      wr_idx[w] = write_register[w*AW +: AW];
      wr_val[w] = write_data[w*WIDTH +: WIDTH];
      wr_ok[w]  = reg_write[w] && addressable(write_register[w*AW +: AW]);
    end
  end

  // Write path. Ports are applied in ascending order so a higher port overrides a lower one
  // on an index collision.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
      if (wr_ok[w]) begin
        regs_d[wr_idx[w]] = wr_val[w];
      end
    end
  end

  // Read path, evaluated per port from the pre-edge contents plus optional forwarding.
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_val;

  always_comb begin
    rdata_d = '0;
    rd_idx  = '0;
    rd_val  = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rd_idx = read_register[p*AW +: AW];
      rd_val = addressable(rd_idx) ? regs_q[rd_idx] : '0;
      if (BYPASS != 0) begin
        // Ascending scan: last match, i.e. the highest-numbered write port, wins.
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
          if (wr_ok[w] && (wr_idx[w] == rd_idx)) begin
            rd_val = wr_val[w];
          end
        end
      end
      rdata_d[p*WIDTH +: WIDTH] = rd_val;
    end
  end

  // Reset dominates: pending writes and reads in a reset cycle are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      rdata_q <= rdata_d;
    end
  end

  assign read_data = rdata_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: three configurations driven in lockstep.
//   dut0: DEPTH=32, 2 read, 2 write, ZERO_REG=31, BYPASS=1
//   dut1: DEPTH=16, 4 read, 2 write, zero register disabled, BYPASS=0
//   dut2: all defaults
module tb_regfile_multiport;

  localparam int NDUT = 3;
  localparam int unsigned CfgRp   [NDUT] = '{2, 4, 2};
  localparam int unsigned CfgWp   [NDUT] = '{2, 2, 1};
  localparam int unsigned CfgDepth[NDUT] = '{32, 16, 32};
  localparam int unsigned CfgZero [NDUT] = '{31, 16, 31};
  localparam int unsigned CfgByp  [NDUT] = '{1, 0, 1};

  typedef struct {
    logic        rst;
    int unsigned rr [4];
    int unsigned wr [2];
    logic [63:0] wd [2];
    logic        we [2];
  } stim_t;

  typedef struct {
    int          d;
    int          p;
    int unsigned edge_no;
    logic [63:0] v;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [9:0]   rr0;
  logic [127:0] rd0;
  logic [9:0]   wr0;
  logic [127:0] wd0;
  logic [1:0]   we0;
  logic [15:0]  rr1;
  logic [255:0] rd1;
  logic [7:0]   wr1;
  logic [127:0] wd1;
  logic [1:0]   we1;
  logic [9:0]   rr2;
  logic [127:0] rd2;
  logic [4:0]   wr2;
  logic [63:0]  wd2;
  logic [0:0]   we2;

  regfile_multiport #(
    .WIDTH(64), .DEPTH(32), .READ_PORTS(2), .WRITE_PORTS(2), .ZERO_REG(31), .BYPASS(1)
  ) dut0 (
    .clk(clk), .reset(rst), .read_register(rr0), .read_data(rd0),
    .write_register(wr0), .write_data(wd0), .reg_write(we0)
  );

  regfile_multiport #(
    .WIDTH(64), .DEPTH(16), .READ_PORTS(4), .WRITE_PORTS(2), .ZERO_REG(16), .BYPASS(0)
  ) dut1 (
    .clk(clk), .reset(rst), .read_register(rr1), .read_data(rd1),
    .write_register(wr1), .write_data(wd1), .reg_write(we1)
  );

  regfile_multiport dut2 (
    .clk(clk), .reset(rst), .read_register(rr2), .read_data(rd2),
    .write_register(wr2), .write_data(wd2), .reg_write(we2)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    passed = 0;
  string phase  = "init";
  exp_t  sb [$];
  logic [63:0] mem [NDUT][32];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] actual(input int d, input int p);
    case (d)
      0:       return rd0[p*64 +: 64];
      1:       return rd1[p*64 +: 64];
      default: return rd2[p*64 +: 64];
    endcase
  endfunction

  // Reference: the register file is an array; a cycle either wipes it or applies the enabled
  // writes in port order (zero register immune). A read sees the array before the cycle, or
  // after it when forwarding is enabled; reset cycles read as 0.
  task automatic model(input int d, input stim_t s);
    logic [63:0] pre  [32];
    logic [63:0] post [32];
    int unsigned idx;
    exp_t        e;
    for (int i = 0; i < 32; i++) begin
      pre[i]  = mem[d][i];
      post[i] = s.rst ? 64'd0 : mem[d][i];
    end
    if (!s.rst) begin
      for (int w = 0; w < int'(CfgWp[d]); w++) begin
        idx = s.wr[w] % CfgDepth[d];
        if (s.we[w] && idx != CfgZero[d]) post[idx] = s.wd[w];
      end
    end
    for (int p = 0; p < int'(CfgRp[d]); p++) begin
      idx       = s.rr[p] % CfgDepth[d];
      e.d       = d;
      e.p       = p;
      e.edge_no = cyc + 1;
      e.tag     = $sformatf("%s dut%0d port%0d X%0d", phase, d, p, idx);
      if (s.rst || idx == CfgZero[d]) e.v = 64'd0;
      else e.v = (CfgByp[d] != 0) ? post[idx] : pre[idx];
      sb.push_back(e);
    end
    for (int i = 0; i < 32; i++) mem[d][i] = post[i];
  endtask

  // Drive one cycle of stimulus just after a rising edge; it is sampled on the next edge.
  task automatic issue(input stim_t s);
    @(posedge clk);
    #1;
    rst = s.rst;
    for (int p = 0; p < 2; p++) rr0[p*5 +: 5] = 5'(s.rr[p] % 32);
    for (int p = 0; p < 4; p++) rr1[p*4 +: 4] = 4'(s.rr[p] % 16);
    for (int p = 0; p < 2; p++) rr2[p*5 +: 5] = 5'(s.rr[p] % 32);
    for (int w = 0; w < 2; w++) begin
      wr0[w*5 +: 5]   = 5'(s.wr[w] % 32);
      wr1[w*4 +: 4]   = 4'(s.wr[w] % 16);
      wd0[w*64 +: 64] = s.wd[w];
      wd1[w*64 +: 64] = s.wd[w];
      we0[w]          = s.we[w];
      we1[w]          = s.we[w];
    end
    wr2    = 5'(s.wr[0] % 32);
    wd2    = s.wd[0];
    we2[0] = s.we[0];
    for (int d = 0; d < NDUT; d++) model(d, s);
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0;
    for (int i = 0; i < 4; i++) s.rr[i] = 0;
    for (int i = 0; i < 2; i++) begin
      s.wr[i] = 0;
      s.wd[i] = 64'd0;
      s.we[i] = 1'b0;
    end
    return s;
  endfunction

  // Monitor: each read port presents a word every cycle; compare it against whatever the
  // scoreboard expects for the edge that just completed.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].edge_no <= cyc) begin
      e = sb.pop_front();
      check(e.tag, actual(e.d, e.p), e.v);
    end
  end

  initial begin
    stim_t s;
    rst = 1'b1;
    rr0 = '0; wr0 = '0; wd0 = '0; we0 = '0;
    rr1 = '0; wr1 = '0; wd1 = '0; we1 = '0;
    rr2 = '0; wr2 = '0; wd2 = '0; we2 = '0;
    for (int d = 0; d < NDUT; d++) for (int i = 0; i < 32; i++) mem[d][i] = 64'd0;

    phase = "reset";
    s = idle(); s.rst = 1'b1; s.rr[0] = 0; s.rr[1] = 5; s.rr[2] = 5; s.rr[3] = 0;
    issue(s);
    s = idle(); s.rr[1] = 5; s.rr[2] = 5;
    issue(s);

    phase = "write_read";
    s = idle(); s.we[0] = 1'b1; s.wr[0] = 0; s.wd[0] = 64'd55;
    issue(s);
    s = idle(); s.rr[0] = 0; s.rr[1] = 12; s.rr[2] = 0; s.rr[3] = 12;
    issue(s);
    s = idle(); s.we[0] = 1'b1; s.wr[0] = 15; s.wd[0] = -64'sd354;
    issue(s);
    s = idle(); for (int p = 0; p < 4; p++) s.rr[p] = 15;
    issue(s);

    phase = "bypass";
    s = idle(); s.we[0] = 1'b1; s.wr[0] = 7; s.wd[0] = 64'd9;
    issue(s);
    s = idle(); s.we[0] = 1'b1; s.wr[0] = 7; s.wd[0] = 64'd23456;
    for (int p = 0; p < 4; p++) s.rr[p] = 7;
    issue(s);
    s = idle(); for (int p = 0; p < 4; p++) s.rr[p] = 7;
    issue(s);

    phase = "zero_reg";
    s = idle(); s.we[0] = 1'b1; s.wr[0] = 31; s.wd[0] = 64'd77;
    for (int p = 0; p < 4; p++) s.rr[p] = 31;
    issue(s);
    s = idle(); for (int p = 0; p < 4; p++) s.rr[p] = 31;
    issue(s);

    phase = "disabled_write";
    s = idle(); s.wr[0] = 15; s.wd[0] = 64'd1234;
    for (int p = 0; p < 4; p++) s.rr[p] = 15;
    issue(s);
    s = idle(); for (int p = 0; p < 4; p++) s.rr[p] = 15;
    issue(s);

    phase = "collision";
    s = idle(); s.we[0] = 1'b1; s.we[1] = 1'b1; s.wr[0] = 3; s.wr[1] = 3;
    s.wd[0] = 64'd10; s.wd[1] = 64'd20;
    issue(s);
    s = idle(); for (int p = 0; p < 4; p++) s.rr[p] = 3;
    issue(s);

    phase = "mid_reset";
    s = idle(); s.rst = 1'b1; s.we[0] = 1'b1; s.wr[0] = 4; s.wd[0] = 64'd99;
    for (int p = 0; p < 4; p++) s.rr[p] = 4;
    issue(s);
    s = idle(); s.rr[0] = 4; s.rr[1] = 3; s.rr[2] = 15; s.rr[3] = 0;
    issue(s);

    // Random mix; indices are biased low half the time so reads often hit fresh writes.
    phase = "random";
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < 4; p++)
        s.rr[p] = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      for (int w = 0; w < 2; w++) begin
        s.wr[w] = $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
        s.wd[w] = {$urandom, $urandom};
        s.we[w] = ($urandom_range(0, 3) != 0);
      end
      issue(s);
    end

    phase = "drain";
    s = idle();
    issue(s);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
Name: regfile_multiport

Overview:
Parametrised, single-clock register file for the decode stage of the LEGv8 datapath. Replaces the split read_clk/write_clk register file with N synchronous read ports and M write ports. Adds write-to-read bypass, a hardwired zero register (XZR) and synchronous reset. Feeds operand registers for execute; written back from the writeback stage.

Parameters:
WIDTH, 64, data word width in bits (matches `WORD)
DEPTH, 32, number of architectural registers; power of two, 2..64
READ_PORTS, 2, number of read ports, 1..4
WRITE_PORTS, 1, number of write ports, 1..2
ZERO_REG, 31, index that always reads 0 and ignores writes; set to DEPTH to disable
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = old contents returned
AW (localparam), $clog2(DEPTH), register index width

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
read_register  input  READ_PORTS*AW  packed read indices, port p at [p*AW +: AW]
read_data  output  READ_PORTS*WIDTH  registered read data, port p at [p*WIDTH +: WIDTH]
write_register  input  WRITE_PORTS*AW  packed write indices
write_data  input  WRITE_PORTS*WIDTH  packed write data
reg_write  input  WRITE_PORTS  per-port write enable

Behaviour:
- Clocking: one clock; reset is synchronous and active-high; reset is sampled only on the rising edge of clk.
- Reset: all DEPTH registers clear to 0, and all read_data outputs clear to 0 on the same edge.
- Reset dominates: writes presented in a reset cycle are discarded. read_data is 0 in the cycle after reset regardless of the read_register values.
- Write: on a rising edge with reg_write[w]=1, register write_register[w] takes write_data[w]. The new value is visible to reads sampled on the following edge.
- Write collision (WRITE_PORTS=2, same index, both enabled): port 1 wins; port 0 is dropped.
- Zero register: writes to ZERO_REG are ignored. Reads of ZERO_REG return 0, including via bypass.
- Read: latency 1 cycle. read_data[p] after edge k equals the contents of read_register[p] as sampled at edge k.
- Bypass, BYPASS=1: if a read index matches an enabled write index in the same cycle, read_data returns that write_data. The highest-numbered matching write port wins. Never applies to ZERO_REG.
- Bypass, BYPASS=0: a same-cycle read returns the pre-write contents.
- Multiple read ports may read the same index. Each port's result is independent and identical.
- Out-of-range index: when DEPTH < 2^AW, a read returns 0 and a write is ignored. Unreachable at the default parameters.
- Width: write_data is stored unmodified, with no sign handling. Stored values are bit-exact, e.g. -354 reads back as 64'hFFFF_FFFF_FFFF_FE9E.
- No X on any output after the first reset edge.

Test Plan:
1. Reset: assert reset for 1 cycle, read registers 0 and 5 -> read_data0=0, read_data1=0 on the cycle after reset.
2. Write then read: write 55 to X0, then read X0 and X12 next cycle -> 55 and 0. Write -354 to X15 and read X15 on both ports -> both return 64'hFFFF_FFFF_FFFF_FE9E.
3. Bypass: in the same cycle write 23456 to X7 and read X7.
   - BYPASS=1 -> read_data=23456 one cycle later.
   - BYPASS=0 with prior value 9 -> 9, then 23456 on the next read.
4. Zero register: write 77 to X31 with reg_write=1, same-cycle and next-cycle reads of X31 -> 0 both times.
5. Disabled write and collision:
   - Set reg_write=0 with write_data=1234 to X15 -> X15 retains its previous value.
   - With WRITE_PORTS=2, both ports write X3 (port0=10, port1=20) -> X3 reads 20.
6. Reset mid-operation: write 99 to X4 in the same cycle reset=1 -> X4 reads 0 afterwards and read_data is 0 in the reset-following cycle. Sweep READ_PORTS=4 and DEPTH=16 with a random write/read mix against a reference model.
